// File: rtl/sync_fifo_flags_if.sv
// rtl/sync_fifo_flags_if.sv - handshake/status bundle for sync_fifo_flags
//
// Purpose: groups the push/pop handshake, data and status signals of the FIFO.
// Ports (signals):
//   flush, write_en, data_in, read_en, clear_err   driven by the master (FIFO user)
//   data_out, data_valid, full, empty,
//   almost_full, almost_empty, count,
//   overflow, underflow                            driven by the slave (FIFO)
interface sync_fifo_flags_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
);
  logic                  flush;
  logic                  write_en;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  read_en;
  logic                  clear_err;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output flush, write_en, data_in, read_en, clear_err,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  flush, write_en, data_in, read_en, clear_err,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with occupancy, threshold and error flags
//
// Purpose: buffers words between datapath stages; FWFT or registered read mode,
// synchronous flush, sticky overflow/underflow.
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset
//   bus   sync_fifo_flags_if.slave: push/pop handshake, data, status and error flags
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 1
) (
  input  logic                clk,
  input  logic                rst,
  sync_fifo_flags_if.slave    bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LIM = (ADDR_WIDTH+1)'(AF_THRESH);
  localparam logic [ADDR_WIDTH:0] AE_LIM = (ADDR_WIDTH+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Extra MSB on each pointer is the wrap bit that separates full from empty.
  logic [ADDR_WIDTH:0]   wr_ptr;
  logic [ADDR_WIDTH:0]   rd_ptr;
  logic [ADDR_WIDTH-1:0] wr_idx;
  logic [ADDR_WIDTH-1:0] rd_idx;
  logic [ADDR_WIDTH:0]   occ;
  logic                  is_full;
  logic                  is_empty;
  logic                  push;
  logic                  pop;
  logic                  ovf_q;
  logic                  unf_q;

  assign wr_idx   = wr_ptr[ADDR_WIDTH-1:0];
  assign rd_idx   = rd_ptr[ADDR_WIDTH-1:0];
  assign occ      = wr_ptr - rd_ptr;
  assign is_empty = (wr_ptr == rd_ptr);
  assign is_full  = (wr_idx == rd_idx) && (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]);

  // Acceptance uses current-cycle flags, so a push into a full FIFO is dropped
  // even when a pop happens in the same cycle. Flush suppresses both.
  assign push = bus.write_en && !is_full  && !bus.flush;
  assign pop  = bus.read_en  && !is_empty && !bus.flush;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= bus.data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Sticky errors: a new error in the same cycle as clear_err wins.
  // A flush cycle leaves both flags untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (!bus.flush) begin
      ovf_q <= (ovf_q && !bus.clear_err) || (bus.write_en && is_full);
      unf_q <= (unf_q && !bus.clear_err) || (bus.read_en && is_empty);
    end
  end

  assign bus.count        = occ;
  assign bus.full         = is_full;
  assign bus.empty        = is_empty;
  assign bus.almost_full  = (occ >= AF_LIM);
  assign bus.almost_empty = (occ <= AE_LIM);
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word shown directly; forced to zero while empty so the output is
      // defined after reset even though storage is not cleared.
      assign bus.data_out   = is_empty ? '0 : mem[rd_idx];
      assign bus.data_valid = !is_empty;
    end else begin : g_reg
      logic [DATA_WIDTH-1:0] dout_q;
      logic                  dv_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          dout_q <= '0;
          dv_q   <= 1'b0;
        end else begin
          dv_q <= pop;
          if (pop) dout_q <= mem[rd_idx];
        end
      end

      assign bus.data_out   = dout_q;
      assign bus.data_valid = dv_q;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags (FWFT and registered modes)
module tb_sync_fifo_flags;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush, we, re, ce;
  logic [31:0] din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_flags_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if1 ();
  sync_fifo_flags_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) if0 ();

  assign if1.flush = flush;  assign if0.flush = flush;
  assign if1.write_en = we;  assign if0.write_en = we;
  assign if1.read_en = re;   assign if0.read_en = re;
  assign if1.clear_err = ce; assign if0.clear_err = ce;
  assign if1.data_in = din;  assign if0.data_in = din;

  sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
  sync_fifo_flags #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .AF_THRESH(12), .AE_THRESH(2), .FWFT(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0.slave));

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model: a queue of stored words plus sticky flags.
  logic [31:0] q[$];
  logic        m_ovf, m_unf, m_dv0, started;
  logic [31:0] m_do0;

  initial begin
    started = 1'b0;
    m_ovf = 1'b0; m_unf = 1'b0; m_dv0 = 1'b0; m_do0 = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_dv0 = 1'b0; m_do0 = '0;
      started = 1'b1;
    end else if (flush) begin
      q.delete();
      m_dv0 = 1'b0;
    end else begin
      automatic bit was_full  = (q.size() == 16);
      automatic bit was_empty = (q.size() == 0);
      m_ovf = (m_ovf && !ce) || (we && was_full);
      m_unf = (m_unf && !ce) || (re && was_empty);
      m_dv0 = re && !was_empty;
      if (re && !was_empty) begin
        m_do0 = q[0];
        void'(q.pop_front());
      end
      if (we && !was_full) q.push_back(din);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      automatic int n = q.size();
      chk("count",        64'(if1.count),        64'(n));
      chk("empty",        64'(if1.empty),        64'(n == 0));
      chk("full",         64'(if1.full),         64'(n == 16));
      chk("almost_full",  64'(if1.almost_full),  64'(n >= 12));
      chk("almost_empty", 64'(if1.almost_empty), 64'(n <= 2));
      chk("overflow",     64'(if1.overflow),     64'(m_ovf));
      chk("underflow",    64'(if1.underflow),    64'(m_unf));
      chk("fwft_valid",   64'(if1.data_valid),   64'(n != 0));
      if (n != 0) chk("fwft_data", 64'(if1.data_out), 64'(q[0]));
      chk("reg_count",    64'(if0.count),        64'(n));
      chk("reg_overflow", 64'(if0.overflow),     64'(m_ovf));
      chk("reg_underflow",64'(if0.underflow),    64'(m_unf));
      chk("reg_valid",    64'(if0.data_valid),   64'(m_dv0));
      chk("reg_data",     64'(if0.data_out),     64'(m_do0));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; re = 1'b0; ce = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0;
    idle();
    cyc(); cyc();
    rst = 1'b0;
    chk("lit_reset_count", 64'(if1.count), 64'd0);
    chk("lit_reset_empty", 64'(if1.empty), 64'd1);
    chk("lit_reset_ae",    64'(if1.almost_empty), 64'd1);
    chk("lit_reset_af",    64'(if1.almost_full), 64'd0);
    chk("lit_reset_dout1", 64'(if1.data_out), 64'd0);
    chk("lit_reset_dv0",   64'(if0.data_valid), 64'd0);

    // 1: fill 0..15, then overflow
    for (int i = 0; i < 16; i++) begin
      we = 1'b1; din = 32'(i);
      cyc();
      chk("lit_fill_count", 64'(if1.count), 64'(i + 1));
      if (i == 10) chk("lit_af_11", 64'(if1.almost_full), 64'd0);
      if (i == 11) chk("lit_af_12", 64'(if1.almost_full), 64'd1);
    end
    chk("lit_full", 64'(if1.full), 64'd1);
    din = 32'd99;
    cyc();
    chk("lit_ovf", 64'(if1.overflow), 64'd1);
    chk("lit_ovf_count", 64'(if1.count), 64'd16);
    ce = 1'b1;
    cyc();
    chk("lit_set_wins", 64'(if1.overflow), 64'd1);
    idle();

    // 2: drain in order, underflow, clear
    for (int i = 0; i < 16; i++) begin
      chk("lit_drain_data", 64'(if1.data_out), 64'(i));
      re = 1'b1;
      cyc();
      chk("lit_reg_data", 64'(if0.data_out), 64'(i));
      if (i == 12) chk("lit_ae_3", 64'(if1.almost_empty), 64'd0);
      if (i == 13) chk("lit_ae_2", 64'(if1.almost_empty), 64'd1);
    end
    chk("lit_empty", 64'(if1.empty), 64'd1);
    cyc();
    chk("lit_unf", 64'(if1.underflow), 64'd1);
    re = 1'b0; ce = 1'b1;
    cyc();
    ce = 1'b0;
    chk("lit_clr_ovf", 64'(if1.overflow), 64'd0);
    chk("lit_clr_unf", 64'(if1.underflow), 64'd0);

    // 3: fill 8, then 40 cycles of simultaneous push/pop
    for (int i = 0; i < 8; i++) begin
      we = 1'b1; din = 32'(100 + i);
      cyc();
    end
    for (int k = 0; k < 40; k++) begin
      chk("lit_stream_data", 64'(if1.data_out), 64'(k < 8 ? 100 + k : 200 + k - 8));
      we = 1'b1; re = 1'b1; din = 32'(200 + k);
      cyc();
      chk("lit_stream_count", 64'(if1.count), 64'd8);
    end
    we = 1'b0;
    for (int i = 0; i < 8; i++) cyc();
    idle();
    chk("lit_stream_noerr", 64'({if1.overflow, if1.underflow}), 64'd0);

    // 4: registered read latency
    we = 1'b1; din = 32'hA5;
    cyc();
    we = 1'b0; re = 1'b1;
    cyc();
    re = 1'b0;
    chk("lit_reg_dv1",  64'(if0.data_valid), 64'd1);
    chk("lit_reg_a5",   64'(if0.data_out), 64'hA5);
    cyc();
    chk("lit_reg_dv0",  64'(if0.data_valid), 64'd0);
    chk("lit_reg_hold", 64'(if0.data_out), 64'hA5);

    // 5: flush with push and pop asserted
    for (int i = 0; i < 10; i++) begin
      we = 1'b1; din = 32'(300 + i);
      cyc();
    end
    we = 1'b1; re = 1'b1; flush = 1'b1;
    cyc();
    idle();
    chk("lit_flush_count", 64'(if1.count), 64'd0);
    chk("lit_flush_empty", 64'(if1.empty), 64'd1);
    chk("lit_flush_noerr", 64'({if1.overflow, if1.underflow}), 64'd0);

    // 6: reset mid-traffic at count 7 with overflow set
    for (int i = 0; i < 17; i++) begin
      we = 1'b1; din = 32'(400 + i);
      cyc();
    end
    we = 1'b0; re = 1'b1;
    for (int i = 0; i < 9; i++) cyc();
    chk("lit_pre_rst_count", 64'(if1.count), 64'd7);
    chk("lit_pre_rst_ovf",   64'(if1.overflow), 64'd1);
    we = 1'b1; rst = 1'b1;
    cyc();
    rst = 1'b0;
    idle();
    chk("lit_rst_count", 64'(if1.count), 64'd0);
    chk("lit_rst_ovf",   64'(if1.overflow), 64'd0);
    chk("lit_rst_dout0", 64'(if0.data_out), 64'd0);
    chk("lit_rst_dv1",   64'(if1.data_valid), 64'd0);
    cyc(); cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
